// File: rtl/lieat_wbu_if.sv
// Bundle of the write-back unit's ALU, long-instruction, hazard-check and wb-stage signals.
// Bypass signals exist only when LIEAT_WBU_BYPASS_EN is defined.
interface lieat_wbu_if #(
    parameter int XLEN    = 32,
    parameter int REG_IDX = 5
);
    logic               alu_valid;
    logic               alu_ready;
    logic [XLEN-1:0]    alu_pc;
    logic               alu_en;
    logic [REG_IDX-1:0] alu_rd;
    logic [XLEN-1:0]    alu_data;
    logic               alu_ebreak;
    logic               longi_push_valid;
    logic               longi_push_ready;
    logic [XLEN-1:0]    longi_push_pc;
    logic [REG_IDX-1:0] longi_push_rd;
    logic               longi_push_lsu;
    logic               longi_ret_valid;
    logic               longi_ret_ready;
    logic [XLEN-1:0]    longi_ret_data;
    logic [REG_IDX-1:0] chk_rs1;
    logic [REG_IDX-1:0] chk_rs2;
    logic               chk_hazard;
    logic               longi_empty;
    logic [XLEN-1:0]    wb_pc;
    logic               wb_valid;
    logic               wb_en;
    logic [REG_IDX-1:0] wb_rd;
    logic [XLEN-1:0]    wb_data;
    logic               wb_lsu;
    logic               wb_ebreak;
`ifdef LIEAT_WBU_BYPASS_EN
    logic               byp_hit1;
    logic               byp_hit2;
    logic [XLEN-1:0]    byp_data;
`endif

    modport master (
        output alu_valid, alu_pc, alu_en, alu_rd, alu_data, alu_ebreak,
        output longi_push_valid, longi_push_pc, longi_push_rd, longi_push_lsu,
        output longi_ret_valid, longi_ret_data, chk_rs1, chk_rs2,
        input  alu_ready, longi_push_ready, longi_ret_ready, chk_hazard, longi_empty,
        input  wb_pc, wb_valid, wb_en, wb_rd, wb_data, wb_lsu, wb_ebreak
`ifdef LIEAT_WBU_BYPASS_EN
        , input byp_hit1, byp_hit2, byp_data
`endif
    );

    modport slave (
        input  alu_valid, alu_pc, alu_en, alu_rd, alu_data, alu_ebreak,
        input  longi_push_valid, longi_push_pc, longi_push_rd, longi_push_lsu,
        input  longi_ret_valid, longi_ret_data, chk_rs1, chk_rs2,
        output alu_ready, longi_push_ready, longi_ret_ready, chk_hazard, longi_empty,
        output wb_pc, wb_valid, wb_en, wb_rd, wb_data, wb_lsu, wb_ebreak
`ifdef LIEAT_WBU_BYPASS_EN
        , output byp_hit1, byp_hit2, byp_data
`endif
    );
endinterface

// File: rtl/lieat_wbu.sv
// Write-back unit: merges ALU results with in-order long-latency returns and reports RAW hazards.
// Optional LIEAT_WBU_BYPASS_EN exposes a wb-stage bypass instead of stalling on wb-stage matches.
module lieat_wbu #(
    parameter int XLEN        = 32,
    parameter int REG_IDX     = 5,
    parameter int LONGI_DEPTH = 4
) (
    input  logic      clock,
    input  logic      reset,
    lieat_wbu_if.slave bus
);
    localparam int AW = $clog2(LONGI_DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      occ;
    logic [XLEN-1:0]    fifo_pc_q  [LONGI_DEPTH];
    logic [XLEN-1:0]    fifo_pc_d  [LONGI_DEPTH];
    logic [REG_IDX-1:0] fifo_rd_q  [LONGI_DEPTH];
    logic [REG_IDX-1:0] fifo_rd_d  [LONGI_DEPTH];
    logic               fifo_lsu_q [LONGI_DEPTH];
    logic               fifo_lsu_d [LONGI_DEPTH];
    logic [LONGI_DEPTH-1:0] entry_vld;

    logic               wb_valid_q, wb_valid_d;
    logic [XLEN-1:0]    wb_pc_q, wb_pc_d;
    logic               wb_en_q, wb_en_d;
    logic [REG_IDX-1:0] wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]    wb_data_q, wb_data_d;
    logic               wb_lsu_q, wb_lsu_d;
    logic               wb_ebreak_q, wb_ebreak_d;

    logic full, empty, push_fire, pop_fire, alu_rdy, alu_fire;
    logic [AW-1:0] head_idx, tail_idx;
    logic fifo_hit1, fifo_hit2, wb_hit1, wb_hit2;

    assign head_idx  = rd_ptr_q[AW-1:0];
    assign tail_idx  = wr_ptr_q[AW-1:0];
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (tail_idx == head_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign push_fire = bus.longi_push_valid & ~full;
    assign pop_fire  = bus.longi_ret_valid & ~empty;
    // An ebreak waits for every older long instruction so it always retires last.
    assign alu_rdy   = ~(bus.longi_ret_valid & ~empty) & ~(bus.alu_ebreak & ~empty);
    assign alu_fire  = bus.alu_valid & alu_rdy;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push_fire);
        rd_ptr_d = rd_ptr_q + PW'(pop_fire);
        for (int i = 0; i < LONGI_DEPTH; i++) begin
            fifo_pc_d[i]  = fifo_pc_q[i];
            fifo_rd_d[i]  = fifo_rd_q[i];
            fifo_lsu_d[i] = fifo_lsu_q[i];
        end
        if (push_fire) begin
            fifo_pc_d[tail_idx]  = bus.longi_push_pc;
            fifo_rd_d[tail_idx]  = bus.longi_push_rd;
            fifo_lsu_d[tail_idx] = bus.longi_push_lsu;
        end
    end

    // An entry is live when its distance from the head is below the occupancy.
    always_comb begin
        occ       = wr_ptr_q - rd_ptr_q;
        entry_vld = '0;
        fifo_hit1 = 1'b0;
        fifo_hit2 = 1'b0;
        for (int i = 0; i < LONGI_DEPTH; i++) begin
            entry_vld[i] = ({1'b0, AW'(AW'(i) - head_idx)} < occ);
            fifo_hit1 = fifo_hit1 | (entry_vld[i] & (fifo_rd_q[i] == bus.chk_rs1));
            fifo_hit2 = fifo_hit2 | (entry_vld[i] & (fifo_rd_q[i] == bus.chk_rs2));
        end
        fifo_hit1 = fifo_hit1 & (bus.chk_rs1 != '0);
        fifo_hit2 = fifo_hit2 & (bus.chk_rs2 != '0);
    end

    assign wb_hit1 = wb_valid_q & wb_en_q & (wb_rd_q == bus.chk_rs1) & (bus.chk_rs1 != '0);
    assign wb_hit2 = wb_valid_q & wb_en_q & (wb_rd_q == bus.chk_rs2) & (bus.chk_rs2 != '0);

    always_comb begin
        wb_valid_d  = pop_fire | alu_fire;
        wb_pc_d     = wb_pc_q;
        wb_en_d     = wb_en_q;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        wb_lsu_d    = wb_lsu_q;
        wb_ebreak_d = wb_ebreak_q;
        if (pop_fire) begin
            wb_pc_d     = fifo_pc_q[head_idx];
            wb_rd_d     = fifo_rd_q[head_idx];
            wb_lsu_d    = fifo_lsu_q[head_idx];
            wb_en_d     = (fifo_rd_q[head_idx] != '0);
            wb_data_d   = bus.longi_ret_data;
            wb_ebreak_d = 1'b0;
        end else if (alu_fire) begin
            wb_pc_d     = bus.alu_pc;
            wb_rd_d     = bus.alu_rd;
            wb_lsu_d    = 1'b0;
            wb_en_d     = bus.alu_en & (bus.alu_rd != '0);
            wb_data_d   = bus.alu_data;
            wb_ebreak_d = bus.alu_ebreak;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            wb_valid_q  <= 1'b0;
            wb_pc_q     <= '0;
            wb_en_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            wb_lsu_q    <= 1'b0;
            wb_ebreak_q <= 1'b0;
            for (int i = 0; i < LONGI_DEPTH; i++) begin
                fifo_pc_q[i]  <= '0;
                fifo_rd_q[i]  <= '0;
                fifo_lsu_q[i] <= 1'b0;
            end
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            wb_valid_q  <= wb_valid_d;
            wb_pc_q     <= wb_pc_d;
            wb_en_q     <= wb_en_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            wb_lsu_q    <= wb_lsu_d;
            wb_ebreak_q <= wb_ebreak_d;
            for (int i = 0; i < LONGI_DEPTH; i++) begin
                fifo_pc_q[i]  <= fifo_pc_d[i];
                fifo_rd_q[i]  <= fifo_rd_d[i];
                fifo_lsu_q[i] <= fifo_lsu_d[i];
            end
        end
    end

    assign bus.alu_ready        = alu_rdy;
    assign bus.longi_push_ready = ~full;
    assign bus.longi_ret_ready  = ~empty;
    assign bus.longi_empty      = empty;
    assign bus.wb_valid         = wb_valid_q;
    assign bus.wb_pc            = wb_pc_q;
    assign bus.wb_en            = wb_en_q;
    assign bus.wb_rd            = wb_rd_q;
    assign bus.wb_data          = wb_data_q;
    assign bus.wb_lsu           = wb_lsu_q;
    assign bus.wb_ebreak        = wb_ebreak_q;

`ifdef LIEAT_WBU_BYPASS_EN
    assign bus.chk_hazard = fifo_hit1 | fifo_hit2;
    assign bus.byp_hit1   = wb_hit1;
    assign bus.byp_hit2   = wb_hit2;
    assign bus.byp_data   = wb_data_q;
`else
    assign bus.chk_hazard = fifo_hit1 | fifo_hit2 | wb_hit1 | wb_hit2;
`endif
endmodule

// File: tb/tb_lieat_wbu.sv
// Directed scoreboard bench for lieat_wbu: a small FIFO model predicts readiness, hazards and wb records.
module tb_lieat_wbu;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic        en;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        lsu;
        logic        ebreak;
    } wb_rec_t;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        lsu;
    } ent_t;

    logic clock;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    wb_rec_t sb[$];
    ent_t    mq[$];
    logic        lw_valid = 1'b0;
    logic        lw_en    = 1'b0;
    logic [4:0]  lw_rd    = '0;
    logic [31:0] lw_data  = '0;

    lieat_wbu_if #(.XLEN(32), .REG_IDX(5)) bus();

    lieat_wbu #(.XLEN(32), .REG_IDX(5), .LONGI_DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.alu_valid        = 1'b0;
        bus.alu_pc           = '0;
        bus.alu_en           = 1'b0;
        bus.alu_rd           = '0;
        bus.alu_data         = '0;
        bus.alu_ebreak       = 1'b0;
        bus.longi_push_valid = 1'b0;
        bus.longi_push_pc    = '0;
        bus.longi_push_rd    = '0;
        bus.longi_push_lsu   = 1'b0;
        bus.longi_ret_valid  = 1'b0;
        bus.longi_ret_data   = '0;
    endtask

    function automatic logic fifo_has(input logic [4:0] rs);
        logic h = 1'b0;
        foreach (mq[i]) if (mq[i].rd == rs) h = 1'b1;
        return h && (rs != 0);
    endfunction

    function automatic logic wb_match(input logic [4:0] rs);
        return lw_valid && lw_en && (lw_rd == rs) && (rs != 0);
    endfunction

    // One clock: predict at the falling edge, compare the wb stage just after the rising edge.
    task automatic cyc();
        logic    m_empty, exp_alu_rdy, acc_ret, acc_alu, acc_push, exp_v, exp_hz;
        wb_rec_t r;
        ent_t    e;
        @(negedge clock);
        m_empty = (mq.size() == 0);
        check("longi_empty", bus.longi_empty, m_empty);
        check("push_ready", bus.longi_push_ready, mq.size() < DEPTH);
        check("ret_ready", bus.longi_ret_ready, !m_empty);
        exp_alu_rdy = !(bus.longi_ret_valid && !m_empty) && !(bus.alu_ebreak && !m_empty);
        check("alu_ready", bus.alu_ready, exp_alu_rdy);
        exp_hz = fifo_has(bus.chk_rs1) || fifo_has(bus.chk_rs2);
`ifdef LIEAT_WBU_BYPASS_EN
        check("byp_hit1", bus.byp_hit1, wb_match(bus.chk_rs1));
        check("byp_hit2", bus.byp_hit2, wb_match(bus.chk_rs2));
        if (wb_match(bus.chk_rs1) || wb_match(bus.chk_rs2)) check("byp_data", bus.byp_data, lw_data);
`else
        exp_hz = exp_hz || wb_match(bus.chk_rs1) || wb_match(bus.chk_rs2);
`endif
        check("chk_hazard", bus.chk_hazard, exp_hz);

        acc_ret  = bus.longi_ret_valid && !m_empty;
        acc_alu  = bus.alu_valid && exp_alu_rdy;
        acc_push = bus.longi_push_valid && (mq.size() < DEPTH);
        exp_v    = acc_ret || acc_alu;
        if (acc_ret) begin
            r = '{pc: mq[0].pc, en: (mq[0].rd != 0), rd: mq[0].rd,
                  data: bus.longi_ret_data, lsu: mq[0].lsu, ebreak: 1'b0};
            sb.push_back(r);
        end else if (acc_alu) begin
            r = '{pc: bus.alu_pc, en: bus.alu_en && (bus.alu_rd != 0), rd: bus.alu_rd,
                  data: bus.alu_data, lsu: 1'b0, ebreak: bus.alu_ebreak};
            sb.push_back(r);
        end
        e = '{pc: bus.longi_push_pc, rd: bus.longi_push_rd, lsu: bus.longi_push_lsu};

        @(posedge clock);
        #1;
        if (acc_ret) void'(mq.pop_front());
        if (acc_push) mq.push_back(e);
        check("wb_valid", bus.wb_valid, exp_v);
        lw_valid = 1'b0;
        if (exp_v && sb.size() > 0) begin
            r = sb.pop_front();
            check("wb_pc", bus.wb_pc, r.pc);
            check("wb_en", bus.wb_en, r.en);
            check("wb_rd", bus.wb_rd, r.rd);
            check("wb_data", bus.wb_data, r.data);
            check("wb_lsu", bus.wb_lsu, r.lsu);
            check("wb_ebreak", bus.wb_ebreak, r.ebreak);
            lw_valid = 1'b1;
            lw_en    = r.en;
            lw_rd    = r.rd;
            lw_data  = r.data;
        end
    endtask

    initial begin
        reset = 1'b0;
        idle();
        bus.chk_rs1 = '0;
        bus.chk_rs2 = '0;
        repeat (2) @(negedge clock);
        check("rst_longi_empty", bus.longi_empty, 1'b1);
        check("rst_wb_valid", bus.wb_valid, 1'b0);
        check("rst_wb_pc", bus.wb_pc, 32'h0);
        check("rst_wb_data", bus.wb_data, 32'h0);
        check("rst_wb_rd", bus.wb_rd, 5'd0);
        reset = 1'b1;
        cyc();

        // ALU result with empty FIFO, then an rd=0 write that must not enable
        bus.alu_valid = 1'b1; bus.alu_pc = 32'h40; bus.alu_en = 1'b1;
        bus.alu_rd = 5'd5; bus.alu_data = 32'h1234;
        cyc();
        bus.alu_rd = 5'd0; bus.alu_pc = 32'h44; bus.alu_data = 32'h55;
        cyc();
        idle(); bus.chk_rs1 = 5'd5;
        cyc();

        // Fill the FIFO with rd 1..4
        for (int k = 1; k <= DEPTH; k++) begin
            bus.longi_push_valid = 1'b1;
            bus.longi_push_pc    = 32'h100 + 32'(k * 4);
            bus.longi_push_rd    = 5'(k);
            bus.longi_push_lsu   = (k % 2) == 1;
            bus.chk_rs1          = 5'd3;
            cyc();
        end

        // Full: push with simultaneous pop is blocked
        bus.longi_push_rd = 5'd9; bus.longi_push_pc = 32'h1f0;
        bus.longi_ret_valid = 1'b1; bus.longi_ret_data = 32'ha1;
        bus.chk_rs2 = 5'd9;
        cyc();
        bus.longi_push_valid = 1'b0;
        bus.longi_ret_data = 32'ha2;
        bus.alu_valid = 1'b1; bus.alu_pc = 32'h50; bus.alu_en = 1'b1;
        bus.alu_rd = 5'd8; bus.alu_data = 32'h8888;
        cyc();
        bus.longi_ret_data = 32'ha3; cyc();
        bus.longi_ret_data = 32'ha4; cyc();
        bus.longi_ret_valid = 1'b0;
        cyc();
        idle(); bus.chk_rs1 = 5'd0;
        cyc();

        // Ebreak waits for the outstanding long instruction
        bus.longi_push_valid = 1'b1; bus.longi_push_rd = 5'd6;
        bus.longi_push_lsu = 1'b1; bus.longi_push_pc = 32'h300;
        cyc();
        bus.longi_push_valid = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_ebreak = 1'b1; bus.alu_pc = 32'h304;
        cyc();
        cyc();
        bus.longi_ret_valid = 1'b1; bus.longi_ret_data = 32'h6666;
        cyc();
        bus.longi_ret_valid = 1'b0;
        cyc();
        idle(); bus.chk_rs2 = 5'd0;
        cyc();

        // Hazard tracking on rd=7
        bus.longi_push_valid = 1'b1; bus.longi_push_rd = 5'd7;
        bus.longi_push_pc = 32'h400; bus.chk_rs1 = 5'd7;
        cyc();
        bus.longi_push_valid = 1'b0;
        cyc();
        bus.chk_rs1 = 5'd0; bus.chk_rs2 = 5'd7;
        cyc();
        bus.chk_rs2 = 5'd0; bus.chk_rs1 = 5'd7;
        bus.longi_ret_valid = 1'b1; bus.longi_ret_data = 32'h7777;
        cyc();
        bus.longi_ret_valid = 1'b0;
        cyc();
        cyc();

        // Return with empty FIFO is ignored
        bus.longi_ret_valid = 1'b1; bus.longi_ret_data = 32'hdead;
        cyc();
        idle(); bus.chk_rs1 = 5'd0;

        // Asynchronous reset with two entries outstanding
        for (int k = 10; k <= 11; k++) begin
            bus.longi_push_valid = 1'b1;
            bus.longi_push_rd    = 5'(k);
            bus.longi_push_pc    = 32'h500 + 32'(k);
            cyc();
        end
        idle();
        check("pre_rst_longi_empty", bus.longi_empty, 1'b0);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_longi_empty", bus.longi_empty, 1'b1);
        check("mid_rst_wb_valid", bus.wb_valid, 1'b0);
        check("mid_rst_push_ready", bus.longi_push_ready, 1'b1);
        mq.delete();
        sb.delete();
        lw_valid = 1'b0; lw_en = 1'b0; lw_rd = '0; lw_data = '0;
        @(negedge clock);
        reset = 1'b1;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lieat_wbu.md
Name: lieat_wbu

Overview:
- Write-back unit on the producer side of the register-file write port; drives wb_pc/wb_valid/wb_en/wb_rd/wb_data/wb_lsu/wb_ebreak and longi_empty.
- Merges single-cycle ALU results with in-order long-latency (LSU/MUL/DIV) returns.
- Tracks outstanding long instructions in a tag FIFO and reports RAW hazards to issue.

Parameters:
XLEN, 32, data/PC width
REG_IDX, 5, register index width
LONGI_DEPTH, 4, outstanding long-instruction FIFO entries (power of 2, ≥2)

Ports:
clock  input  1  clock
reset  input  1  asynchronous reset, active-low
alu_valid  input  1  ALU result offered
alu_ready  output  1  ALU result accepted this cycle
alu_pc  input  XLEN  ALU instruction PC
alu_en  input  1  ALU instruction writes rd
alu_rd  input  REG_IDX  ALU destination
alu_data  input  XLEN  ALU result
alu_ebreak  input  1  instruction is ebreak
longi_push_valid  input  1  long instruction dispatched
longi_push_ready  output  1  FIFO can accept
longi_push_pc  input  XLEN  long instruction PC
longi_push_rd  input  REG_IDX  long instruction destination
longi_push_lsu  input  1  long instruction is load/store
longi_ret_valid  input  1  long result returned (always FIFO head, in order)
longi_ret_ready  output  1  return accepted
longi_ret_data  input  XLEN  returned data
chk_rs1  input  REG_IDX  issue-stage source 1
chk_rs2  input  REG_IDX  issue-stage source 2
chk_hazard  output  1  source depends on unwritten result
longi_empty  output  1  no long instruction outstanding
wb_pc  output  XLEN  write-back PC
wb_valid  output  1  instruction retires this cycle
wb_en  output  1  register write enable
wb_rd  output  REG_IDX  write destination
wb_data  output  XLEN  write data
wb_lsu  output  1  retiring instruction is LSU
wb_ebreak  output  1  retiring instruction is ebreak

Behaviour:
- Reset (reset=0, async): FIFO pointers cleared, all wb_* = 0, longi_empty = 1.
- FIFO: wr/rd pointers of log2(LONGI_DEPTH)+1 bits; full when indices are equal and MSBs differ; empty when pointers are equal.
- longi_push_ready = ~full; push updates on the clock edge when push_valid & push_ready. Push and pop in the same cycle are both legal; push into a full FIFO is blocked even if a pop occurs in that cycle.
- longi_ret_ready = ~empty. A return with an empty FIFO is a protocol error; it is ignored and not accepted.
- Arbitration: a long return accepted in a cycle has priority, so alu_ready = 0 that cycle.
- alu_ready = ~(longi_ret_valid & ~empty) & ~(alu_ebreak & ~empty). An ebreak is held until the FIFO drains and always retires last.
- Registered wb stage, 1-cycle latency: on an accepted event, wb_valid = 1 the next cycle, otherwise 0. wb_* fields other than wb_valid hold their last value when idle.
- Long return: wb_pc/wb_rd/wb_lsu taken from the FIFO head, wb_data = longi_ret_data, wb_en = (head rd != 0), wb_ebreak = 0.
- ALU: wb_* taken from alu_*, wb_en = alu_en & (alu_rd != 0), wb_lsu = 0.
- longi_empty = FIFO empty, combinational from pointers.
- chk_hazard = 1 when, for chk_rs1 or chk_rs2 nonzero, either:
  - any valid FIFO entry has the same rd, or
  - (macro off only) wb_valid & wb_en & wb_rd matches.
- x0 never hazards.

Optional Feature:
- LIEAT_WBU_BYPASS_EN defined:
  - Adds outputs byp_hit1 (1), byp_hit2 (1), byp_data (XLEN).
  - byp_hitN = wb_valid & wb_en & (wb_rd == chk_rsN) & (chk_rsN != 0); byp_data = wb_data.
  - A wb-stage match does not raise chk_hazard.
- LIEAT_WBU_BYPASS_EN undefined: these ports are absent and a wb-stage match raises chk_hazard.

Test Plan:
- Reset mid-stream with 2 FIFO entries → next cycle: longi_empty = 1, wb_valid = 0, longi_push_ready = 1.
- ALU alu_rd=5, alu_en=1, alu_data=0x1234 with FIFO empty → next cycle: wb_valid = 1, wb_rd = 5, wb_data = 0x1234, wb_lsu = 0.
- Push 4 entries (rd 1..4) → longi_push_ready = 0. Simultaneous pop and push → push blocked. Returns pop in order rd 1, 2, 3, 4 with wb_lsu taken from each push.
- longi_ret_valid and alu_valid in the same cycle, FIFO non-empty → alu_ready = 0; long result retires first, ALU retires the following cycle.
- alu_ebreak with 1 outstanding entry → alu_ready = 0 until the return retires; ebreak retires next with wb_ebreak = 1.
- FIFO holds rd=7, chk_rs1 = 7 → chk_hazard = 1; chk_rs1 = 0 → chk_hazard = 0. After the rd=7 retire cycle: hazard with macro off, byp_hit1 = 1 and no hazard with macro on.
